// File: rtl/fib_sequence_checker.sv
// fib_sequence_checker: watches a stream of 32-bit terms from an upstream
// Fibonacci generator and flags the first term that breaks the sequence
// 0, 1, 1, 2, 3, 5, ...
//
// Compile-time option:
//   FIB_CHK_OVF_EN - when defined, a 33-bit carry out of the running sum
//                    parks the checker in OVF and sets the sticky ovf flag.
//                    When undefined, the checker compares against the
//                    wrapped 32-bit sum, and ovf is tied to 0.
//
// Handshake: a term is consumed on every rising edge where in_valid=1 and
// the FSM is in IDLE, SEED1 or CHECK. There is no ready signal; one term per
// clock is always accepted. clear outranks in_valid in the same cycle.
// All outputs are registered and reflect a term one cycle after it is taken.
module fib_sequence_checker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] fib,
    input  logic        clear,
    output logic [15:0] term_count,
    output logic [31:0] expected,
    output logic        err,
    output logic [15:0] err_index,
    output logic [31:0] err_value,
    output logic        ovf,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED1 = 3'd1,
        S_CHECK = 3'd2,
        S_FAIL  = 3'd3,
        S_OVF   = 3'd4
    } state_t;

    state_t      state_q;
    logic [31:0] prev1_q;
    logic [31:0] prev2_q;
    logic [15:0] term_count_q;
    logic [31:0] expected_q;
    logic        err_q;
    logic [15:0] err_index_q;
    logic [31:0] err_value_q;
    logic [15:0] term_count_d;

`ifdef FIB_CHK_OVF_EN
    // Full 33-bit sum so the carry can be inspected.
    logic [32:0] sum_d;
    logic        ovf_q;
    assign sum_d = {1'b0, prev1_q} + {1'b0, prev2_q};
    assign ovf   = ovf_q;
`else
    // Wrapped 32-bit sum; the carry is deliberately discarded.
    logic [31:0] sum_d;
    assign sum_d = prev1_q + prev2_q;
    assign ovf   = 1'b0;
`endif

    // Saturating increment of the accepted-term counter.
    assign term_count_d = (term_count_q == 16'hFFFF) ? term_count_q
                                                     : term_count_q + 16'd1;

    // Sequence-check FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            prev1_q      <= 32'd0;
            prev2_q      <= 32'd0;
            term_count_q <= 16'd0;
            expected_q   <= 32'd0;
            err_q        <= 1'b0;
            err_index_q  <= 16'd0;
            err_value_q  <= 32'd0;
`ifdef FIB_CHK_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else if (clear) begin
            state_q      <= S_IDLE;
            prev1_q      <= 32'd0;
            prev2_q      <= 32'd0;
            term_count_q <= 16'd0;
            expected_q   <= 32'd0;
            err_q        <= 1'b0;
            err_index_q  <= 16'd0;
            err_value_q  <= 32'd0;
`ifdef FIB_CHK_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else if (in_valid) begin
            case (state_q)
                S_IDLE: begin
                    term_count_q <= term_count_d;
                    if (fib == 32'd0) begin
                        prev2_q    <= 32'd0;
                        expected_q <= prev1_q;
                        state_q    <= S_SEED1;
                    end else begin
                        err_q       <= 1'b1;
                        err_index_q <= term_count_q;
                        err_value_q <= fib;
                        state_q     <= S_FAIL;
                    end
                end
                S_SEED1: begin
                    term_count_q <= term_count_d;
                    if (fib == 32'd1) begin
                        prev1_q    <= 32'd1;
                        expected_q <= 32'd1 + prev2_q;
                        state_q    <= S_CHECK;
                    end else begin
                        err_q       <= 1'b1;
                        err_index_q <= term_count_q;
                        err_value_q <= fib;
                        state_q     <= S_FAIL;
                    end
                end
                S_CHECK: begin
`ifdef FIB_CHK_OVF_EN
                    if (sum_d[32]) begin
                        // Sum no longer fits in 32 bits: stop without judging the term.
                        ovf_q   <= 1'b1;
                        state_q <= S_OVF;
                    end else
`endif
                    if (fib == sum_d[31:0]) begin
                        term_count_q <= term_count_d;
                        prev2_q      <= prev1_q;
                        prev1_q      <= fib;
                        expected_q   <= prev1_q + fib;
                    end else begin
                        term_count_q <= term_count_d;
                        err_q        <= 1'b1;
                        err_index_q  <= term_count_q;
                        err_value_q  <= fib;
                        state_q      <= S_FAIL;
                    end
                end
                default: begin
                    // FAIL and OVF hold until clear or reset.
                end
            endcase
        end
    end

    assign state      = state_q;
    assign term_count = term_count_q;
    assign expected   = expected_q;
    assign err        = err_q;
    assign err_index  = err_index_q;
    assign err_value  = err_value_q;

endmodule

// File: tb/tb_fib_sequence_checker.sv
// Bench for fib_sequence_checker: directed scenarios plus randomized streams,
// checked every cycle against a model that tracks the accepted sequence.
module tb_fib_sequence_checker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] fib;
    logic        clear;
    logic [15:0] term_count;
    logic [31:0] expected;
    logic        err;
    logic [15:0] err_index;
    logic [31:0] err_value;
    logic        ovf;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

`ifdef FIB_CHK_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    fib_sequence_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .fib        (fib),
        .clear      (clear),
        .term_count (term_count),
        .expected   (expected),
        .err        (err),
        .err_index  (err_index),
        .err_value  (err_value),
        .ovf        (ovf),
        .state      (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // The model remembers the last two good terms, how many sequence terms
    // have been seen, and whether the run has already failed or overflowed.
    logic [63:0] m_a;      // older of the last two good terms
    logic [63:0] m_b;      // newer of the last two good terms
    int          m_n;      // good terms seen (unbounded)
    int          m_cnt;    // saturating accepted-term count
    bit          m_fail;
    bit          m_ovf;
    int          m_eidx;
    logic [31:0] m_eval;

    task automatic model_reset();
        m_a = 0; m_b = 0; m_n = 0; m_cnt = 0;
        m_fail = 0; m_ovf = 0; m_eidx = 0; m_eval = 0;
    endtask

    function automatic logic [63:0] model_next();
        if (m_n == 0) return 64'd0;
        if (m_n == 1) return 64'd1;
        return m_a + m_b;
    endfunction

    function automatic int model_state();
        if (m_fail) return 3;
        if (m_ovf)  return 4;
        if (m_n == 0) return 0;
        if (m_n == 1) return 1;
        return 2;
    endfunction

    task automatic model_step(input logic v, input logic [31:0] f, input logic c);
        logic [63:0] nxt;
        if (c) begin
            model_reset();
        end else if (v && !m_fail && !m_ovf) begin
            nxt = model_next();
            if (OVF_EN && m_n >= 2 && nxt > 64'hFFFF_FFFF) begin
                m_ovf = 1'b1;
            end else begin
                if ({32'd0, f} != (nxt & 64'hFFFF_FFFF)) begin
                    m_fail = 1'b1;
                    m_eidx = m_cnt;
                    m_eval = f;
                end else begin
                    m_a = m_b;
                    m_b = {32'd0, f};
                    m_n++;
                end
                if (m_cnt < 65535) m_cnt++;
            end
        end
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [63:0] sum;
        int ms;
        ms  = model_state();
        sum = (m_a + m_b) & 64'hFFFF_FFFF;
        chk("state",      {29'd0, state},      ms[31:0]);
        chk("term_count", {16'd0, term_count}, m_cnt[31:0]);
        chk("err",        {31'd0, err},        {31'd0, m_fail});
        chk("err_index",  {16'd0, err_index},  m_fail ? m_eidx[31:0] : 32'd0);
        chk("err_value",  err_value,           m_fail ? m_eval : 32'd0);
        chk("ovf",        {31'd0, ovf},        {31'd0, m_ovf});
        if (ms == 2) chk("expected", expected, sum[31:0]);
    end

    // ---------------- driver ----------------
    // Presents inputs on the falling edge, lets the rising edge take them,
    // then advances the model just after that edge.
    task automatic drive(input logic v, input logic [31:0] f, input logic c);
        @(negedge clk);
        in_valid = v;
        fib      = f;
        clear    = c;
        @(posedge clk);
        #1;
        model_step(v, f, c);
    endtask

    logic [63:0] fibs [0:48];

    task automatic do_clear();
        drive(1'b0, 32'd0, 1'b1);
        drive(1'b0, 32'd0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] nx;
        logic [31:0] w1, w2, w3;
        logic        v, c;
        logic [31:0] f;
        int          r;

        fibs[0] = 0;
        fibs[1] = 1;
        for (int i = 2; i <= 48; i++) fibs[i] = fibs[i-1] + fibs[i-2];

        model_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        fib      = 32'd0;
        clear    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'd0, 1'b0);

        // Reset state
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_term_count", {16'd0, term_count}, 32'd0);

        // F(0)..F(20) back to back
        for (int i = 0; i <= 20; i++) drive(1'b1, fibs[i][31:0], 1'b0);
        chk("f20_term_count", {16'd0, term_count}, 32'd21);
        chk("f20_expected", expected, 32'd10946);
        chk("f20_err", {31'd0, err}, 32'd0);
        chk("f20_state", {29'd0, state}, 32'd2);

        // 0,1,1,2,4 -> failure at index 4, later terms ignored
        do_clear();
        drive(1'b1, 32'd0, 1'b0);
        drive(1'b1, 32'd1, 1'b0);
        drive(1'b1, 32'd1, 1'b0);
        drive(1'b1, 32'd2, 1'b0);
        drive(1'b1, 32'd4, 1'b0);
        drive(1'b1, 32'd5, 1'b0);
        drive(1'b1, 32'd8, 1'b0);
        chk("bad4_err", {31'd0, err}, 32'd1);
        chk("bad4_err_index", {16'd0, err_index}, 32'd4);
        chk("bad4_err_value", err_value, 32'd4);
        chk("bad4_state", {29'd0, state}, 32'd3);
        chk("bad4_term_count", {16'd0, term_count}, 32'd5);

        // First term wrong
        do_clear();
        drive(1'b1, 32'd5, 1'b0);
        chk("first5_state", {29'd0, state}, 32'd3);
        chk("first5_err_index", {16'd0, err_index}, 32'd0);
        chk("first5_err_value", err_value, 32'd5);

        // F(0)..F(47), then a 48th term the upstream clips to all-ones
        do_clear();
        for (int i = 0; i <= 47; i++) drive(1'b1, fibs[i][31:0], 1'b0);
        drive(1'b1, 32'hFFFF_FFFF, 1'b0);
        if (OVF_EN) begin
            chk("f48_ovf", {31'd0, ovf}, 32'd1);
            chk("f48_term_count", {16'd0, term_count}, 32'd48);
            chk("f48_err", {31'd0, err}, 32'd0);
            chk("f48_state", {29'd0, state}, 32'd4);
        end else begin
            chk("f48_err", {31'd0, err}, 32'd1);
            chk("f48_err_index", {16'd0, err_index}, 32'd48);
            chk("f48_state", {29'd0, state}, 32'd3);
            chk("f48_ovf", {31'd0, ovf}, 32'd0);
        end

        // clear together with in_valid while in CHECK
        do_clear();
        for (int i = 0; i <= 4; i++) drive(1'b1, fibs[i][31:0], 1'b0);
        drive(1'b1, 32'd5, 1'b1);
        chk("clr_state", {29'd0, state}, 32'd0);
        chk("clr_term_count", {16'd0, term_count}, 32'd0);
        chk("clr_expected", expected, 32'd0);
        chk("clr_err", {31'd0, err}, 32'd0);
        drive(1'b1, 32'd0, 1'b0);
        drive(1'b1, 32'd1, 1'b0);
        drive(1'b1, 32'd1, 1'b0);
        chk("clr_resume_count", {16'd0, term_count}, 32'd3);
        chk("clr_resume_state", {29'd0, state}, 32'd2);

        // Asynchronous reset between clock edges mid-CHECK
        drive(1'b1, 32'd2, 1'b0);
        drive(1'b0, 32'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_state", {29'd0, state}, 32'd0);
        chk("arst_term_count", {16'd0, term_count}, 32'd0);
        chk("arst_expected", expected, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'd0, 1'b0);

        // Randomized streams: mostly correct terms, some bad terms, gaps, clears
        for (int k = 0; k < 3000; k++) begin
            nx = model_next();
            if (m_fail || m_ovf) c = ($urandom_range(0, 4) == 0);
            else                 c = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 19);
            if (r == 0)      f = $urandom;
            else if (r == 1) f = nx[31:0] + 32'd1;
            else             f = nx[31:0];
            drive(v, f, c);
        end

`ifndef FIB_CHK_OVF_EN
        // Wrapped sequence long enough to saturate the term counter
        do_clear();
        drive(1'b1, 32'd0, 1'b0);
        drive(1'b1, 32'd1, 1'b0);
        w1 = 32'd0;
        w2 = 32'd1;
        for (int i = 2; i < 65540; i++) begin
            w3 = w1 + w2;
            drive(1'b1, w3, 1'b0);
            w1 = w2;
            w2 = w3;
        end
        chk("sat_term_count", {16'd0, term_count}, 32'h0000_FFFF);
        chk("sat_err", {31'd0, err}, 32'd0);
`endif

        drive(1'b0, 32'd0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fib_sequence_checker.md
FIB_SEQUENCE_CHECKER -- requirements
Module: fib_sequence_checker

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_valid  input  1  fib carries a new term this cycle.
REQ-004 SHALL have ports: fib  input  32  term from the upstream Fibonacci generator, unsigned.
REQ-005 SHALL have ports: clear  input  1  synchronous restart of the check.
REQ-006 SHALL have ports: term_count  output  16  number of terms accepted since reset/clear.
REQ-007 SHALL have ports: expected  output  32  value the next term must take (valid in CHECK).
REQ-008 SHALL have ports: err  output  1  sticky mismatch flag.
REQ-009 SHALL have ports: err_index  output  16  term index (0-based) of the first mismatch.
REQ-010 SHALL have ports: err_value  output  32  fib value received at the first mismatch.
REQ-011 SHALL have ports: ovf  output  1  sticky 32-bit overflow flag (tied 0 when REQ-030 is compiled out).
REQ-012 SHALL have ports: state  output  3  current FSM state encoding, for debug.

Function
REQ-013 SHALL implement FSM states: IDLE=0, SEED1=1, CHECK=2, FAIL=3, OVF=4.
REQ-014 SHALL register all outputs, updating them one cycle after the qualifying in_valid edge.
REQ-015 SHALL, in IDLE on in_valid: if fib==0, store prev2=0 and go to SEED1; otherwise go to FAIL.
REQ-016 SHALL, in SEED1 on in_valid: if fib==1, store prev1=1 and go to CHECK; otherwise go to FAIL.
REQ-017 SHALL, in CHECK, compute expected = prev1 + prev2 as a 33-bit sum.
REQ-018 SHALL, in CHECK on in_valid with fib==expected[31:0] (and no overflow per REQ-030), shift prev2<=prev1 and prev1<=fib.
REQ-019 SHALL, in CHECK on in_valid with fib!=expected[31:0], go to FAIL.
REQ-020 SHALL, on entry to FAIL, set err=1, latch err_index=term_count and latch err_value=fib.
REQ-021 SHALL hold FAIL and OVF until clear or reset; in_valid SHALL be ignored in both states.
REQ-022 SHALL increment term_count on every in_valid accepted in IDLE, SEED1 and CHECK, including the failing term.
REQ-023 SHALL saturate term_count at 16'hFFFF with no wrap.
REQ-024 SHALL give clear priority over in_valid in the same cycle.
REQ-025 SHALL, on clear, return to IDLE and zero all registers and outputs, exactly as reset does.
REQ-026 SHALL perform no action on a cycle with in_valid=0, with all registers holding.
REQ-027 SHALL accept back-to-back in_valid every cycle, so full throughput is one term per clock.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force: state=IDLE, term_count=0, expected=0, err=0, err_index=0, err_value=0, ovf=0, prev1=prev2=0.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; a reset mid-sequence SHALL discard all history.

Configuration
REQ-030 SHALL include overflow detection when macro FIB_CHK_OVF_EN is defined: in CHECK on in_valid with expected[32]==1, go to OVF, set ovf=1, do not compare, do not set err, and do not increment term_count.
REQ-031 SHALL, without FIB_CHK_OVF_EN, omit the OVF state logic, tie ovf to 0, and compare against expected[31:0] (wrapped sum) per REQ-018/019.

Verification
REQ-032 SHALL be verified by: reset, then stream F(0)..F(20) on consecutive cycles -> err=0, term_count=21, expected=10946 after the last term.
REQ-033 SHALL be verified by: stream 0,1,1,2,4 -> err=1, err_index=4, err_value=4, state=FAIL; further terms leave term_count=5.
REQ-034 SHALL be verified by: first term 5 -> FAIL, err_index=0, err_value=5.
REQ-035 SHALL be verified by: stream F(0)..F(48) with FIB_CHK_OVF_EN defined -> ovf=1 at F(48), term_count=48, err=0. Without the macro, the same stream gives err=1 at index 48, since the wrapped expected value 512559680 differs from the upstream value.
REQ-036 SHALL be verified by: clear asserted together with in_valid in CHECK -> IDLE, all outputs 0. A subsequent 0,1,1 is then accepted with term_count=3.
REQ-037 SHALL be verified by: rst_n pulsed low asynchronously mid-CHECK between clock edges -> outputs zero immediately, with no clock edge required.
